// File: rtl/tmr_pkg.sv
// Shared types for the TMR vote/scrub block.
//   state_t     - scrub sequencer states
//   LANE_*      - bit positions of each replica in a lane mask
//   lane_mask_t - one bit per replica, bit0=A, bit1=B, bit2=C
package tmr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIX    = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_t;

    localparam int LANE_A = 0;
    localparam int LANE_B = 1;
    localparam int LANE_C = 2;

    typedef logic [2:0] lane_mask_t;

endpackage

// File: rtl/tmr_maj3.sv
// Bitwise 2-of-3 majority vote.
//   a, b, c : replica values (true polarity)
//   y       : per-bit majority
module tmr_maj3 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] y
);

    assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/tmr_vote_scrub.sv
// Majority voter and scrub controller for a bank of triplicated set-type
// flops with inverted (QN) outputs.
//   clk, rn            : clock, asynchronous active-low reset
//   qn_a/qn_b/qn_c     : inverted replica outputs
//   scrub_en           : allows a new scrub to start from IDLE
//   clr                : synchronous clear of err_cnt/err_sticky/hard_fail
//   q_out              : registered majority vote, true polarity
//   d_fix, fix_en,
//   fix_lane           : corrected value, load strobe and lane select
//   busy               : sequencer not in IDLE
//   err_cnt            : saturating count of scrub events
//   err_sticky         : a mismatch has started a scrub since last clear
//   hard_fail          : a mismatch survived every retry
module tmr_vote_scrub
    import tmr_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_W     = 8,
    parameter int MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             rn,
    input  logic [WIDTH-1:0] qn_a,
    input  logic [WIDTH-1:0] qn_b,
    input  logic [WIDTH-1:0] qn_c,
    input  logic             scrub_en,
    input  logic             clr,
    output logic [WIDTH-1:0] q_out,
    output logic [WIDTH-1:0] d_fix,
    output logic             fix_en,
    output logic [2:0]       fix_lane,
    output logic             busy,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_sticky,
    output logic             hard_fail
);

    localparam logic [2:0]       RETRY_LAST = 3'(MAX_RETRY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [WIDTH-1:0] sa, sb, sc;
    logic [WIDTH-1:0] v;
    lane_mask_t       lane;
    logic             mm;
    logic [2:0]       retry;
    state_t           state, state_next;

    // Sequencer decode strobes
    logic start;     // IDLE -> FIX entry of a new event
    logic again;     // CHECK -> FIX retry
    logic give_up;   // CHECK -> IDLE with the mismatch still present
    logic clean;     // CHECK -> IDLE with the lanes agreeing

    // Stage 1: invert back to true polarity. Reset value all-ones matches
    // replicas that read as set (QN = 0).
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            sa <= '1;
            sb <= '1;
            sc <= '1;
        end else begin
            sa <= ~qn_a;
            sb <= ~qn_b;
            sc <= ~qn_c;
        end
    end

    tmr_maj3 #(.WIDTH(WIDTH)) u_maj (
        .a (sa),
        .b (sb),
        .c (sc),
        .y (v)
    );

    always_comb begin
        lane         = '0;
        lane[LANE_A] = |(sa ^ v);
        lane[LANE_B] = |(sb ^ v);
        lane[LANE_C] = |(sc ^ v);
        mm           = |lane;
    end

    // Output vote keeps running independent of the sequencer.
    always_ff @(posedge clk or negedge rn) begin
        if (!rn) q_out <= '1;
        else     q_out <= v;
    end

    always_ff @(posedge clk or negedge rn) begin
        if (!rn) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_next = state;
        fix_en     = 1'b0;
        start      = 1'b0;
        again      = 1'b0;
        give_up    = 1'b0;
        clean      = 1'b0;
        unique case (state)
            IDLE: begin
                if (mm && scrub_en && !hard_fail) begin
                    state_next = FIX;
                    start      = 1'b1;
                end
            end
            FIX: begin
                fix_en     = 1'b1;
                state_next = SETTLE;
            end
            // Replicas load at the end of FIX; the sample regs only see the
            // rewritten value at the end of SETTLE, so CHECK is the first
            // cycle that can judge the scrub.
            SETTLE: state_next = CHECK;
            CHECK: begin
                if (!mm) begin
                    state_next = IDLE;
                    clean      = 1'b1;
                end else if (retry < RETRY_LAST) begin
                    state_next = FIX;
                    again      = 1'b1;
                end else begin
                    state_next = IDLE;
                    give_up    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Scrub payload and retry counter.
    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            d_fix    <= '1;
            fix_lane <= '0;
            retry    <= '0;
        end else if (start || again) begin
            d_fix    <= v;
            fix_lane <= lane;
            retry    <= start ? 3'd0 : retry + 3'd1;
        end else if (clean) begin
            fix_lane <= '0;
        end
    end

    // Error bookkeeping; clr takes priority over same-edge updates.
    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            err_cnt    <= '0;
            err_sticky <= 1'b0;
            hard_fail  <= 1'b0;
        end else if (clr) begin
            err_cnt    <= '0;
            err_sticky <= 1'b0;
            hard_fail  <= 1'b0;
        end else begin
            if (start) begin
                err_sticky <= 1'b1;
                if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_W'(1);
            end
            if (give_up) hard_fail <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tmr_vote_scrub.sv
// Self-checking bench for tmr_vote_scrub. A replica model (true-polarity
// values per lane) drives the QN inputs and reloads on fix_en; expected
// votes, lane masks and counts are derived from that model.
module tb_tmr_vote_scrub;

    localparam int W    = 8;
    localparam int MAXR = 2;

    logic         clk = 1'b0;
    logic         rn;
    logic [W-1:0] qn_a, qn_b, qn_c;
    logic         scrub_en, clr;

    logic [W-1:0] q_out, d_fix;
    logic         fix_en, busy, err_sticky, hard_fail;
    logic [2:0]   fix_lane;
    logic [7:0]   err_cnt;

    logic [W-1:0] q_out2, d_fix2;
    logic         fix_en2, busy2, err_sticky2, hard_fail2;
    logic [2:0]   fix_lane2;
    logic [1:0]   err_cnt2;

    tmr_vote_scrub #(.WIDTH(W), .CNT_W(8), .MAX_RETRY(MAXR)) dut (
        .clk(clk), .rn(rn), .qn_a(qn_a), .qn_b(qn_b), .qn_c(qn_c),
        .scrub_en(scrub_en), .clr(clr), .q_out(q_out), .d_fix(d_fix),
        .fix_en(fix_en), .fix_lane(fix_lane), .busy(busy), .err_cnt(err_cnt),
        .err_sticky(err_sticky), .hard_fail(hard_fail)
    );

    tmr_vote_scrub #(.WIDTH(W), .CNT_W(2), .MAX_RETRY(MAXR)) dut2 (
        .clk(clk), .rn(rn), .qn_a(qn_a), .qn_b(qn_b), .qn_c(qn_c),
        .scrub_en(scrub_en), .clr(clr), .q_out(q_out2), .d_fix(d_fix2),
        .fix_en(fix_en2), .fix_lane(fix_lane2), .busy(busy2), .err_cnt(err_cnt2),
        .err_sticky(err_sticky2), .hard_fail(hard_fail2)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] r [3];          // replica contents, true polarity
    int           stuck_lane = -1;
    logic [W-1:0] v_prev;         // vote of the value sampled at the previous edge
    logic         fix_seen = 1'b0;
    logic [2:0]   cap_lane;
    logic [W-1:0] cap_dfix;
    int           pulses = 0;
    int           events = 0;     // scrub events since last clear

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_vote(input logic [W-1:0] a, b, c);
        logic [W-1:0] res;
        for (int i = 0; i < W; i++) begin
            int n;
            n = int'(a[i]) + int'(b[i]) + int'(c[i]);
            res[i] = (n >= 2);
        end
        return res;
    endfunction

    function automatic logic [2:0] ref_mask(input logic [W-1:0] v);
        logic [2:0] m;
        for (int l = 0; l < 3; l++) m[l] = (r[l] != v);
        return m;
    endfunction

    function automatic int sat(input int n, input int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    task automatic drive();
        qn_a = ~r[0];
        qn_b = ~r[1];
        qn_c = ~r[2];
    endtask

    // One clock: apply replica reloads after the edge, then sample at negedge.
    task automatic cycle();
        logic [W-1:0] v_now;
        logic [W-1:0] exp_q;
        @(posedge clk);
        v_now = ref_vote(r[0], r[1], r[2]);
        #1;
        if (fix_seen)
            for (int l = 0; l < 3; l++)
                if (cap_lane[l] && l != stuck_lane) r[l] = cap_dfix;
        drive();
        @(negedge clk);
        exp_q  = v_prev;
        v_prev = v_now;
        check("q_out", q_out, exp_q);
        fix_seen = fix_en;
        if (fix_en) begin
            pulses++;
            cap_lane = fix_lane;
            cap_dfix = d_fix;
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_cnt"},  err_cnt,  sat(events, 255));
        check({tag, "_cnt2"}, err_cnt2, sat(events, 3));
    endtask

    // Replicas already carry the upset; run the scrub to completion.
    task automatic run_event(input string tag, input int exp_pulses, input bit clr_at_entry);
        logic [W-1:0] v;
        logic [2:0]   m;
        v = ref_vote(r[0], r[1], r[2]);
        m = ref_mask(v);
        drive();
        pulses = 0;
        cycle();
        check({tag, "_idle_before_fix"}, busy, 0);
        if (clr_at_entry) clr = 1'b1;
        cycle();
        clr = 1'b0;
        check({tag, "_fix_en"},   fix_en,   1);
        check({tag, "_fix_lane"}, fix_lane, m);
        check({tag, "_d_fix"},    d_fix,    v);
        if (clr_at_entry) begin
            check({tag, "_clr_cnt"},    err_cnt,    0);
            check({tag, "_clr_sticky"}, err_sticky, 0);
        end else begin
            events++;
            check_counts(tag);
            check({tag, "_sticky"}, err_sticky, 1);
        end
        for (int i = 0; i < 40 && busy; i++) cycle();
        check({tag, "_done"},   busy,   0);
        check({tag, "_pulses"}, pulses, exp_pulses);
    endtask

    task automatic set_all(input logic [W-1:0] val);
        for (int l = 0; l < 3; l++) r[l] = val;
        drive();
    endtask

    initial begin
        logic [W-1:0] base;
        logic [W-1:0] v;
        int           lane_sel;
        int           bit_sel;

        // Reset with all replicas set.
        rn = 1'b0; scrub_en = 1'b0; clr = 1'b0;
        set_all('1);
        v_prev = '1;
        #12;
        check("rst_q_out",  q_out,    8'hFF);
        check("rst_d_fix",  d_fix,    8'hFF);
        check("rst_fix_en", fix_en,   0);
        check("rst_lane",   fix_lane, 0);
        check("rst_busy",   busy,     0);
        check("rst_cnt",    err_cnt,  0);
        rn = 1'b1;
        pulses = 0;
        cycles(5);
        check("post_rst_q_out",  q_out,  8'hFF);
        check("post_rst_busy",   busy,   0);
        check("post_rst_cnt",    err_cnt, 0);
        check("post_rst_pulses", pulses, 0);

        // Single-lane upset on B: QN 5A -> 5B.
        scrub_en = 1'b1;
        set_all(8'hA5);
        cycles(4);
        r[1] = 8'hA4;
        run_event("laneB", 1, 1'b0);
        check("laneB_q_out", q_out, 8'hA5);
        check("laneB_repaired", r[1], 8'hA5);
        check("laneB_hf", hard_fail, 0);

        // Stuck lane B: retries exhaust, then no further scrubs.
        base = 8'($urandom);
        set_all(base);
        cycles(4);
        stuck_lane = 1;
        r[1] = base ^ 8'h10;
        run_event("stuck", MAXR, 1'b0);
        check("stuck_hf", hard_fail, 1);
        pulses = 0;
        cycles(10);
        check("stuck_blocked_pulses", pulses, 0);
        check("stuck_blocked_busy",   busy,   0);
        check_counts("stuck_blocked");
        stuck_lane = -1;
        r[1] = base;
        drive();
        cycles(3);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        events = 0;
        check("clr_hf",     hard_fail,  0);
        check("clr_sticky", err_sticky, 0);
        check_counts("clr");

        // Random single-lane upsets; 2-bit counter saturates at 3.
        for (int k = 0; k < 4; k++) begin
            base = 8'($urandom);
            set_all(base);
            cycles(4);
            lane_sel = int'($urandom_range(0, 2));
            bit_sel  = int'($urandom_range(0, W - 1));
            r[lane_sel][bit_sel] = ~r[lane_sel][bit_sel];
            run_event("rand", 1, 1'b0);
            check("rand_repaired", r[lane_sel], base);
        end

        // Two lanes flipped in the same bit: vote follows the flipped pair
        // and the untouched lane is the one rewritten.
        base = 8'($urandom);
        set_all(base);
        cycles(4);
        bit_sel = int'($urandom_range(0, W - 1));
        r[0][bit_sel] = ~r[0][bit_sel];
        r[1][bit_sel] = ~r[1][bit_sel];
        v = r[0];
        run_event("two_lane", 1, 1'b0);
        check("two_lane_c", r[2], v);
        check_counts("five");

        // clr coincident with IDLE->FIX entry.
        base = 8'($urandom);
        set_all(base);
        cycles(4);
        r[2] = base ^ 8'h01;
        run_event("clr_entry", 1, 1'b1);
        events = 0;
        check_counts("clr_entry_after");
        check("clr_entry_sticky", err_sticky, 0);

        // Reset pulsed during SETTLE.
        base = 8'($urandom);
        set_all(base);
        cycles(4);
        r[0] = base ^ 8'h80;
        drive();
        cycles(3);
        check("settle_busy", busy, 1);
        rn = 1'b0;
        #1;
        check("mid_rst_q_out",  q_out,      8'hFF);
        check("mid_rst_d_fix",  d_fix,      8'hFF);
        check("mid_rst_fix_en", fix_en,     0);
        check("mid_rst_lane",   fix_lane,   0);
        check("mid_rst_busy",   busy,       0);
        check("mid_rst_cnt",    err_cnt,    0);
        check("mid_rst_sticky", err_sticky, 0);
        check("mid_rst_hf",     hard_fail,  0);
        v_prev   = '1;
        fix_seen = 1'b0;
        #1;
        rn = 1'b1;
        pulses = 0;
        cycles(6);
        check("post_mid_rst_pulses", pulses, 0);
        check("post_mid_rst_busy",   busy,   0);
        check("post_mid_rst_q_out",  q_out,  base);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tmr_vote_scrub.md
Name: tmr_vote_scrub

Overview:
- Downstream consumer of a bank of triplicated set-type flops, each with an active-low set and an inverted QN output.
- Samples the three replica QN buses and produces a registered, true-polarity majority-voted value.
- Detects replica disagreement and drives a scrub sequence that rewrites the faulty lane(s) with the voted value.
- Keeps a saturating upset counter and sticky error/hard-fail flags for the radiation-hardened datapath.

Parameters:
- WIDTH, 8, bits per replica register.
- CNT_W, 8, width of the saturating upset counter.
- MAX_RETRY, 2, scrub attempts per event before HARD_FAIL is declared (1..7).

Ports:
- CLK  in  1  clock, all state on rising edge.
- RN  in  1  reset; asynchronous, active-low.
- QN_A  in  WIDTH  inverted output of replica A.
- QN_B  in  WIDTH  inverted output of replica B.
- QN_C  in  WIDTH  inverted output of replica C.
- SCRUB_EN  in  1  permits starting a new scrub from IDLE.
- CLR  in  1  synchronous clear of ERR_CNT, ERR_STICKY, HARD_FAIL.
- Q_OUT  out  WIDTH  registered majority vote, true polarity.
- D_FIX  out  WIDTH  corrected value (true polarity) for the replica D inputs.
- FIX_EN  out  1  one-cycle load strobe for lanes selected by FIX_LANE.
- FIX_LANE  out  3  lane select, bit0=A, bit1=B, bit2=C.
- BUSY  out  1  high in any state other than IDLE.
- ERR_CNT  out  CNT_W  saturating count of scrub events.
- ERR_STICKY  out  1  set on any detected mismatch.
- HARD_FAIL  out  1  set when a mismatch survives MAX_RETRY scrubs.

Behaviour:
- Reset (RN low, asynchronous):
  - Sample regs = all-zero QN, i.e. replicas read as set.
  - Q_OUT = all ones, D_FIX = all ones.
  - FIX_EN = 0, FIX_LANE = 0, ERR_CNT = 0, ERR_STICKY = 0, HARD_FAIL = 0, retry = 0, state = IDLE.
  - Reset mid-scrub abandons the sequence with no FIX_EN glitch.
- Stage 1: register SA/SB/SC = ~QN_A/~QN_B/~QN_C each cycle.
- Vote: V = bitwise maj(SA,SB,SC). Q_OUT <= V, so latency is 2 cycles from QN to Q_OUT.
- Mismatch: MM = |((SA^V)|(SB^V)|(SC^V)). Lane mask L = {|(SC^V), |(SB^V), |(SA^V)}.
- FSM states: IDLE, FIX, SETTLE, CHECK.
  - IDLE:
    - If MM && SCRUB_EN && !HARD_FAIL -> FIX.
    - On that entry: latch D_FIX <= V and FIX_LANE <= L, set retry = 0, ERR_CNT += 1 (saturating at 2^CNT_W-1), ERR_STICKY <= 1.
  - FIX: FIX_EN = 1 for exactly this cycle -> SETTLE.
  - SETTLE: FIX_EN = 0. One wait cycle, because the replicas load at the end of FIX and the sample regs capture at the end of SETTLE -> CHECK.
  - CHECK:
    - If !MM -> IDLE and clear FIX_LANE.
    - Else if retry < MAX_RETRY-1: retry++, relatch D_FIX <= V and FIX_LANE <= L -> FIX. No additional count.
    - Else set HARD_FAIL <= 1 -> IDLE.
- HARD_FAIL blocks new scrubs until CLR. Q_OUT keeps voting regardless.
- SCRUB_EN deasserted mid-sequence: the current FIX/SETTLE/CHECK sequence completes; only new entry from IDLE is gated.
- CLR: ERR_CNT, ERR_STICKY and HARD_FAIL clear on the same edge. CLR wins over a simultaneous increment or set. FSM state is not affected.
- Counter at saturation stays at max, but ERR_STICKY and the scrub still occur.
- A two-lane upset in the same bit is not detectable. The vote follows the majority and is scrubbed into the minority lane; this is documented and not flagged.

Decomposition:
- Package tmr_pkg:
  - state enum {IDLE, FIX, SETTLE, CHECK};
  - lane index constants LANE_A=0, LANE_B=1, LANE_C=2;
  - lane-mask typedef (3 bits).
- Sub-module tmr_maj3: parameterised WIDTH, combinational bitwise 2-of-3 vote; instantiated once for V.

Test Plan:
- Reset release with QN_A=QN_B=QN_C=8'h00 -> Q_OUT=8'hFF, BUSY=0, ERR_CNT=0; no FIX_EN ever.
- All QN=8'h5A steady, then QN_B=8'h5B at cycle 10, SCRUB_EN=1 (bench replica model reloads on FIX_EN):
  - Q_OUT stays 8'hA5.
  - FIX_EN at cycle 12 with FIX_LANE=3'b010 and D_FIX=8'hA5.
  - ERR_CNT=1, ERR_STICKY=1; back in IDLE at cycle 15.
- Same as previous, but the bench ignores FIX_EN on lane B (stuck fault), MAX_RETRY=2 -> exactly two FIX_EN pulses, then HARD_FAIL=1, ERR_CNT=1; no further scrubs until CLR.
- CLR asserted in the same cycle as an IDLE->FIX entry with ERR_CNT=5 -> ERR_CNT=0 and ERR_STICKY=0 after the edge; the FIX_EN pulse still follows.
- CNT_W=2: four separate single-lane upsets -> ERR_CNT reads 1,2,3,3 and every event is still scrubbed.
- RN pulsed low during SETTLE -> all outputs return immediately to reset values; state=IDLE after release; no FIX_EN asserted on release.
